// File: rtl/data_sram_resp.sv
// Byte-writable 32-bit data SRAM with registered read data and optional wait-state handshake.
// Define DSRAM_WAIT_STATE_EN to make every access take two cycles (IDLE/WAIT FSM driving stallreq).
module data_sram_resp #(
    parameter int ADDR_WD = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    localparam int DEPTH = 1 << ADDR_WD;

    logic [31:0]        mem [DEPTH];
    logic [ADDR_WD-1:0] idx;
    logic               do_access;
    logic               unused_addr_bits;

    // Word index only; byte offset and upper bits alias into the array.
    assign idx              = data_sram_addr[ADDR_WD+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WD+2], data_sram_addr[1:0]};

`ifdef DSRAM_WAIT_STATE_EN
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request cycle only raises the stall; the access happens in WAIT with held inputs.
    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        do_access = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_sram_en) begin
                    stallreq  = ~rst;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                do_access = data_sram_en & ~rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    assign stallreq  = 1'b0;
    assign do_access = data_sram_en & ~rst;
`endif

    // Array update: byte lanes follow the write enables, contents survive reset.
    always_ff @(posedge clk) begin
        if (do_access) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_we[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    // Read data register: loads only on a completed read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst)                                  data_sram_rdata <= 32'h0;
        else if (do_access && data_sram_we == 4'h0) data_sram_rdata <= mem[idx];
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed-vector bench for data_sram_resp; follows DSRAM_WAIT_STATE_EN when defined.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [19];

    data_sram_resp #(.ADDR_WD(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
    endtask

    // One transaction to completion; inputs held across the wait cycle when enabled.
    task automatic xact(input string nm, input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
`ifdef DSRAM_WAIT_STATE_EN
        #1;
        check({nm, "_stall_req"}, {31'h0, stallreq}, {31'h0, en});
        if (en) begin
            step();
            check({nm, "_stall_wait"}, {31'h0, stallreq}, 32'h0);
        end
`else
        #1;
        check({nm, "_stall"}, {31'h0, stallreq}, 32'h0);
`endif
        step();
        idle_inputs();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_4010, 32'h1234_5678, 32'hDEAA_BEEF};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'h1234_5678};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAA_BEEF, 32'h1234_5678};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[9]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[12] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_0055, 32'hDEAA_BEEF};
        vecs[13] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[14] = '{1'b1, 4'hF, 32'h0000_0024, 32'h0000_0000, 32'hDEAA_BEEF};
        vecs[15] = '{1'b1, 4'h1, 32'h0000_0024, 32'hFFFF_FFA5, 32'hDEAA_BEEF};
        vecs[16] = '{1'b1, 4'h8, 32'h0000_0024, 32'h5AFF_FFFF, 32'hDEAA_BEEF};
        vecs[17] = '{1'b1, 4'h0, 32'h0000_0024, 32'h0000_0000, 32'h5A00_00A5};
        vecs[18] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0055};

        // Reset with a read request pending: nothing may complete.
        rst = 1'b1;
        data_sram_en    = 1'b1;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0000_0010;
        data_sram_wdata = 32'h0;
        step();
        step();
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_stall", {31'h0, stallreq}, 32'h0);
        idle_inputs();
        rst = 1'b0;
        #1;
        check("post_reset_rdata", data_sram_rdata, 32'h0);
        check("post_reset_stall", {31'h0, stallreq}, 32'h0);

        for (int i = 0; i < 19; i++) begin
            xact($sformatf("vec%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), data_sram_rdata, vecs[i].exp_rdata);
        end

        // Back-to-back reads of 0x10 held for four cycles (rdata starts at 0x55).
        data_sram_en   = 1'b1;
        data_sram_we   = 4'h0;
        data_sram_addr = 32'h0000_0010;
        for (int c = 0; c < 4; c++) begin
            #1;
`ifdef DSRAM_WAIT_STATE_EN
            check($sformatf("b2b_stall_c%0d", c), {31'h0, stallreq}, (c % 2 == 0) ? 32'h1 : 32'h0);
`else
            check($sformatf("b2b_stall_c%0d", c), {31'h0, stallreq}, 32'h0);
`endif
            step();
            if (c == 0) begin
`ifdef DSRAM_WAIT_STATE_EN
                check("b2b_rdata_c0", data_sram_rdata, 32'h0000_0055);
`else
                check("b2b_rdata_c0", data_sram_rdata, 32'hDEAA_BEEF);
`endif
            end
        end
        check("b2b_rdata_end", data_sram_rdata, 32'hDEAA_BEEF);
        idle_inputs();
        step();

        // Write aborted by reset: the prior word must survive.
        data_sram_en    = 1'b1;
        data_sram_we    = 4'hF;
        data_sram_addr  = 32'h0000_0010;
        data_sram_wdata = 32'hBADB_AD00;
`ifdef DSRAM_WAIT_STATE_EN
        #1;
        check("abort_stall_req", {31'h0, stallreq}, 32'h1);
        step();
`endif
        rst = 1'b1;
        #1;
        check("abort_stall_in_rst", {31'h0, stallreq}, 32'h0);
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("abort_rdata", data_sram_rdata, 32'h0);
        check("abort_stall", {31'h0, stallreq}, 32'h0);
        xact("abort_read", 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check("abort_read_rdata", data_sram_rdata, 32'hDEAA_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_WD, default 12: word-index width; array depth is 2**ADDR_WD 32-bit words.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port data_sram_en, input, 1: access request valid this cycle.
REQ-005 SHALL have port data_sram_we, input, 4: per-byte write enables; all-zero with en=1 means read.
REQ-006 SHALL have port data_sram_addr, input, 32: byte address.
REQ-007 SHALL have port data_sram_wdata, input, 32: write data, byte lanes aligned to we bits.
REQ-008 SHALL have port data_sram_rdata, output, 32: registered read data.
REQ-009 SHALL have port stallreq, output, 1: pipeline stall request.

Function
REQ-010 SHALL index the array with data_sram_addr[ADDR_WD+1:2]; addr[1:0] and bits above ADDR_WD+1 are ignored, so higher addresses alias (wrap) into the array.
REQ-011 SHALL, on an accepted write, update only byte lanes whose we bit is 1 (we[3] -> bits 31:24 ... we[0] -> bits 7:0); other lanes unchanged.
REQ-012 SHALL, on an accepted read, load the full 32-bit word into data_sram_rdata at the completing edge; value visible the cycle after completion.
REQ-013 SHALL hold data_sram_rdata unchanged on cycles with no completed read, including write cycles.
REQ-014 SHALL return newly written data for a read to the same word issued in the cycle after the write completes (no stale read).
REQ-015 SHALL ignore we, addr, wdata when data_sram_en=0.

Reset
REQ-016 SHALL drive data_sram_rdata=0, stallreq=0 and FSM state IDLE during and immediately after rst.
REQ-017 SHALL NOT clear array contents on reset; contents are undefined until written.
REQ-018 SHALL abort any in-progress access when rst is asserted: no write is committed and rdata stays 0.

Configuration
REQ-019 Macro DSRAM_WAIT_STATE_EN SHALL select wait-state operation.
REQ-020 Without the macro: every access completes in its request cycle; stallreq tied 0; no FSM.
REQ-021 With the macro: two-state FSM IDLE/WAIT; in IDLE with en=1, stallreq=1 combinationally and next state WAIT, no array or rdata update.
REQ-022 With the macro, in WAIT: access performed using inputs present that cycle (requester holds them stable), stallreq=0, next state IDLE.
REQ-023 With the macro, en=1 in the cycle after WAIT SHALL be treated as a new request (back-to-back accesses each take 2 cycles).
REQ-024 With the macro, rst asserted in WAIT SHALL return FSM to IDLE with no write committed.

Verification
REQ-025 Write addr=0x10, we=4'hF, wdata=0xDEADBEEF; read 0x10 -> rdata=0xDEADBEEF the cycle after the read.
REQ-026 Then write 0x10, we=4'b0100, wdata=0x00AA0000; read -> rdata=0xDEAABEEF.
REQ-027 With ADDR_WD=12, write 0x4010 = 0x12345678, read 0x0010 -> 0x12345678 (alias); read 0x0013 -> same word.
REQ-028 Read 0x10 then idle 3 cycles, then write 0x20 -> rdata holds 0xDEAABEEF throughout.
REQ-029 Macro on: read request -> stallreq=1 in cycle 0, 0 in cycle 1, rdata valid cycle 2; two consecutive requests -> stallreq pattern 1,0,1,0.
REQ-030 Macro on: write request, rst asserted in WAIT cycle -> subsequent read of that address returns prior contents; rdata=0, stallreq=0 after reset.
